rs232_tx: RTL and testbench

Byte-wide RS-232 transmitter: the transmit half of the team's UART, paired with the existing receive path. Accepts bytes on a one-cycle `Send` strobe into a small FIFO. Serializes each byte as an 8N1 frame (optionally 8E1) on `TX`, with a fixed clock-divider bit period. Sits between user logic and the board TX pin.

---
 rtl/rs232_pkg.sv | 24 ++
 rtl/rs232_tx_fifo.sv | 61 ++++++
 rtl/rs232_tx.sv | 216 +++++++++++++++++++++
 tb/tb_rs232_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions used by both the transmit and receive paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rs232_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 32;

  // Serial frame sequencer states. PARITY is only entered by builds that
  // enable the parity bit; the encoding is shared so rx and tx agree.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rs232_state_e;

  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rs232_tx_fifo.sv
// Byte queue between the user write strobe and the transmit sequencer.
// Latency: a pushed entry is visible at head/empty/count the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; the caller reports drops.
//
// Ports:
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   push, push_data     write strobe and data (ignored when full)
//   pop                 remove the head entry (ignored when empty)
//   head                current head entry
//   full, empty, count  occupancy, all derived from the registered count
module rs232_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rs232_tx.sv
// RS-232 transmitter: queues bytes from a one-cycle Send strobe and shifts them out 8N1
// (8E1/8E2 when RS232_TX_PARITY_EN is defined). Latency: TX falls two edges after Send from idle.
// Backpressure: none towards the sender; a Send while Full is dropped and Overflow pulses once.
//
// Ports:
//   Clock      rising-edge clock
//   Reset      synchronous active-high reset; abandons the frame and empties the queue
//   WriteLine  byte sampled when Send is high
//   Send       one-cycle write strobe, one byte per high cycle
//   TX         serial line, idle high, driven straight from a flop
//   Busy       queue non-empty or a frame in progress (registered)
//   Full       queue holds FIFO_DEPTH bytes
//   Overflow   one-cycle pulse after a dropped Send
// Build option: define RS232_TX_PARITY_EN to insert an even parity bit after data bit 7.
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] WriteLine,
  input  logic       Send,
  output logic       TX,
  output logic       Busy,
  output logic       Full,
  output logic       Overflow
);

  localparam int                    BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                    CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0]     LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic                  LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [2:0]            LAST_BIT  = 3'(DATA_BITS - 1);

  rs232_state_e           state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q;
`ifdef RS232_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic                   bit_done;
  logic                   fifo_pop;
  logic                   fifo_push;
  logic [DATA_BITS-1:0]   fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          count_d;

  // Full is the registered occupancy, so a pop on the same edge cannot rescue a push.
  assign fifo_push = Send && !fifo_full;

  rs232_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (fifo_push),
    .push_data (WriteLine),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bit_done = (baud_q == LAST_BAUD);

  // Next-state logic. Outputs are registered from the next state so that TX
  // changes on the same edge as the state and no input reaches TX combinationally.
  always_comb begin
    state_d    = state_q;
    baud_d     = bit_done ? '0 : baud_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
`ifdef RS232_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
`ifdef RS232_TX_PARITY_EN
          parity_d = even_parity(fifo_head);
`endif
          state_d  = START;
        end
      end

      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end

      // The bit index only ever leaves 7 by leaving DATA, so it never wraps.
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef RS232_TX_PARITY_EN
            state_d    = PARITY;
`else
            state_d    = STOP;
`endif
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef RS232_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
`endif

      // On the last stop cycle a queued byte starts immediately, with no idle gap.
      STOP: begin
        if (bit_done) begin
          if (stop_idx_q == LAST_STOP) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_head;
`ifdef RS232_TX_PARITY_EN
              parity_d = even_parity(fifo_head);
`endif
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Every start bit begins a fresh bit period.
    if (state_d == START && state_q != START) baud_d = '0;
  end

  // Line level and busy flag as they will be after this edge.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef RS232_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase

    count_d = fifo_count;
    if (fifo_push && !fifo_pop)      count_d = fifo_count + 1'b1;
    else if (!fifo_push && fifo_pop) count_d = fifo_count - 1'b1;

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef RS232_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovf_q      <= Send && fifo_full;
`ifdef RS232_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign TX       = tx_q;
  assign Busy     = busy_q;
  assign Full     = fifo_full;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_rs232_tx.sv
// Self-checking bench for rs232_tx: every cycle compares TX/Busy/Full/Overflow with a
// timeline model of accepted bytes, plus table-driven frames and directed corner cases.
// A simple receiver decodes the line for byte-level checks.
module tb_rs232_tx;

  localparam int CPB   = 32;
  localparam int STOPB = 1;
  localparam int DEPTH = 4;
`ifdef RS232_TX_PARITY_EN
  localparam int PBIT  = 1;
`else
  localparam int PBIT  = 0;
`endif
  localparam int NBITS = 1 + 8 + PBIT + STOPB;
  localparam int FRAME = NBITS * CPB;
  localparam int NEVER = 32'h7fff_ffff;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Send  = 1'b0;
  logic [7:0] WriteLine = 8'h00;
  logic       TX, Busy, Full, Overflow;

  rs232_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .WriteLine(WriteLine), .Send(Send),
    .TX(TX), .Busy(Busy), .Full(Full), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endfunction

  // ---------------- reference model: timeline of accepted bytes ----------------
  // Each accepted byte lives in the queue from its push edge until its pop edge,
  // and its frame occupies FRAME cycles starting right after the pop edge.
  logic [7:0] m_data[$];
  int         m_push[$];
  int         m_pop[$];
  int         m_kill[$];
  int         m_drop[$];
  int         last_end = -1000000;

  function automatic int occupancy(input int e);
    int n = 0;
    for (int i = 0; i < m_push.size(); i++)
      if (m_push[i] <= e && e < m_pop[i] && e < m_kill[i]) n++;
    return n;
  endfunction

  function automatic void model_send(input logic [7:0] d, input int n_edge);
    int p;
    if (occupancy(n_edge - 1) >= DEPTH) begin
      m_drop.push_back(n_edge);
    end else begin
      p = (n_edge + 1 > last_end) ? n_edge + 1 : last_end;
      m_data.push_back(d);
      m_push.push_back(n_edge);
      m_pop.push_back(p);
      m_kill.push_back(NEVER);
      last_end = p + FRAME;
    end
  endfunction

  function automatic void model_reset(input int r_edge);
    for (int i = 0; i < m_kill.size(); i++)
      if (m_kill[i] > r_edge) m_kill[i] = r_edge;
    last_end = -1000000;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (PBIT == 1 && k == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic void expect_at(input int e, output logic tx, output logic busy,
                                    output logic full, output logic ovf);
    int n;
    tx = 1'b1; busy = 1'b0; ovf = 1'b0;
    for (int i = 0; i < m_pop.size(); i++)
      if (m_pop[i] <= e && e < m_pop[i] + FRAME && e < m_kill[i]) begin
        tx   = frame_bit(m_data[i], (e - m_pop[i]) / CPB);
        busy = 1'b1;
      end
    n = occupancy(e);
    if (n != 0) busy = 1'b1;
    full = (n == DEPTH);
    foreach (m_drop[j]) if (m_drop[j] == e) ovf = 1'b1;
  endfunction

  // ---------------- per-cycle comparison against the model ----------------
  bit   chk_en = 1'b0;
  logic e_tx, e_busy, e_full, e_ovf;
  always @(negedge Clock) begin
    if (chk_en) begin
      expect_at(cyc, e_tx, e_busy, e_full, e_ovf);
      check("TX", TX, e_tx);
      check("Busy", Busy, e_busy);
      check("Full", Full, e_full);
      check("Overflow", Overflow, e_ovf);
    end
  end

  // ---------------- line receiver ----------------
  bit         rx_on = 1'b0;
  int         rx_start = 0, rx_k = 0, rx_b = 0;
  logic [7:0] rx_sh = 8'h00;
  logic       rx_par = 1'b0;
  logic       rx_prev = 1'b1;
  logic [7:0] rx_bytes[$];
  int         rx_starts[$];
  int         ovf_seen = 0, full_seen = 0;

  always @(negedge Clock) begin
    if (Overflow === 1'b1) ovf_seen++;
    if (Full === 1'b1) full_seen++;
    if (Reset === 1'b1) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (rx_prev === 1'b1 && TX === 1'b0) begin
        rx_on = 1'b1;
        rx_start = cyc;
      end
    end else begin
      rx_k = cyc - rx_start;
      if (rx_k % CPB == CPB / 2) begin
        rx_b = rx_k / CPB;
        if (rx_b >= 1 && rx_b <= 8) rx_sh[rx_b-1] = TX;
        else if (PBIT == 1 && rx_b == 9) rx_par = TX;
        if (rx_b == NBITS - 1) begin
          rx_bytes.push_back(rx_sh);
          rx_starts.push_back(rx_start);
          rx_on = 1'b0;
        end
      end
    end
    rx_prev = TX;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    WriteLine = d;
    Send = 1'b1;
    model_send(d, cyc + 1);
    tick();
    Send = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((Busy !== 1'b0 || TX !== 1'b1) && n < limit) begin
      tick();
      n++;
    end
    check("idle_timeout", (n < limit) ? 32'd1 : 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // {stop, data LSB..MSB order, start} with bit 0 = start bit
    logic       par;
  } vec_t;
  vec_t vecs[6];

  int   t0, tgt, n0, acc0, lows;
  logic ebit;

  initial begin
    vecs[0] = '{8'h55, 10'h2AA, 1'b0};
    vecs[1] = '{8'hA3, 10'h346, 1'b0};
    vecs[2] = '{8'h07, 10'h20E, 1'b1};
    vecs[3] = '{8'h03, 10'h206, 1'b0};
    vecs[4] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[5] = '{8'h00, 10'h200, 1'b0};

    // Reset, then idle: the per-cycle checker expects TX=1 and all flags low.
    Reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    repeat (100) tick();

    // Table of single frames: latency, every bit centre, frame length via Busy.
    for (int i = 0; i < 6; i++) begin
      wait_idle(4 * FRAME);
      t0 = cyc + 1;
      send(vecs[i].data);
      check("tx_before_pop", TX, 1);
      tick();
      check("tx_start_latency", TX, 0);
      for (int b = 0; b < NBITS; b++) begin
        tgt = t0 + 1 + b * CPB + CPB / 2;
        while (cyc < tgt) tick();
        if (b <= 8) ebit = vecs[i].frame[b];
        else if (PBIT == 1 && b == 9) ebit = vecs[i].par;
        else ebit = vecs[i].frame[9];
        check("frame_bit", TX, ebit);
      end
      while (cyc < t0 + FRAME) tick();
      check("busy_last_stop", Busy, 1);
      tick();
      check("busy_after_frame", Busy, 0);
    end

    // Two bytes on consecutive cycles: no idle gap between frames.
    wait_idle(4 * FRAME);
    n0 = rx_bytes.size();
    send(8'hA3);
    send(8'h0F);
    wait_idle(4 * FRAME);
    check("b2b_frames", rx_bytes.size() - n0, 2);
    if (rx_bytes.size() >= n0 + 2) begin
      check("b2b_byte0", rx_bytes[n0], 8'hA3);
      check("b2b_byte1", rx_bytes[n0+1], 8'h0F);
      check("b2b_spacing", rx_starts[n0+1] - rx_starts[n0], FRAME);
    end

    // Six back-to-back sends into a 4-deep queue: one drop, five frames.
    n0 = rx_bytes.size();
    ovf_seen = 0;
    full_seen = 0;
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
    wait_idle(8 * FRAME);
    check("ovf_pulses", ovf_seen, 1);
    check("full_seen", (full_seen != 0) ? 32'd1 : 32'd0, 1);
    check("burst_frames", rx_bytes.size() - n0, 5);
    for (int i = 0; i < 5 && n0 + i < rx_bytes.size(); i++)
      check("burst_byte", rx_bytes[n0+i], 8'h10 + 8'(i));

    // Reset in the middle of the data bits of 0xFF with two bytes queued.
    n0 = rx_bytes.size();
    t0 = cyc + 1;
    send(8'hFF);
    send(8'h11);
    send(8'h22);
    while (cyc < t0 + 1 + 3 * CPB + 5) tick();
    check("pre_reset_full_count", Full, 0);
    Reset = 1'b1;
    model_reset(cyc + 1);
    tick();
    Reset = 1'b0;
    check("reset_tx", TX, 1);
    check("reset_busy", Busy, 0);
    check("reset_full", Full, 0);
    lows = 0;
    repeat (2 * FRAME) begin
      tick();
      if (TX !== 1'b1) lows++;
    end
    check("reset_no_frames", lows, 0);
    check("reset_rx_count", rx_bytes.size() - n0, 0);

    // Randomised bursts and gaps against the timeline model.
    n0 = rx_bytes.size();
    acc0 = m_data.size();
    for (int it = 0; it < 50; it++) begin
      int burst, gap;
      burst = $urandom_range(1, 6);
      gap = $urandom_range(0, FRAME + 40);
      for (int j = 0; j < burst; j++) send(8'($urandom));
      repeat (gap) tick();
    end
    wait_idle((DEPTH + 2) * FRAME);
    check("rand_frames", rx_bytes.size() - n0, m_data.size() - acc0);
    for (int i = 0; i < m_data.size() - acc0 && n0 + i < rx_bytes.size(); i++)
      check("rand_byte", rx_bytes[n0+i], m_data[acc0+i]);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
    $fatal(1);
  end

endmodule
